regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 72 +++++++
 rtl/regfile_scoreboard.sv | 80 ++++++++
 tb/tb_regfile_scoreboard.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared MIPS register-file package: default geometry and the register index type.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_AW       = $clog2(RF_NUM_REGS);

  // Architectural register index for the default 32-entry file.
  typedef logic [RF_AW-1:0] regIdx_t;

  // Register 0 is hardwired to zero and never becomes pending.
  localparam regIdx_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: one bit per register plus a registered
// count of set bits, with per-read-port busy flags.
module rf_scoreboard
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(NUM_REGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issueValid,
  input  logic [AW-1:0]        issueDest,
  input  logic                 wbValid,
  input  logic [AW-1:0]        wbReg,
  input  logic                 flush,
  input  logic [NUM_RD*AW-1:0] rdAddr,
  output logic [NUM_RD-1:0]    rdBusy,
  output logic [CW-1:0]        pendCount
);

  logic [NUM_REGS-1:0] pending;
  logic                setHit;
  logic                incr;
  logic                decr;

  // A claim on r0 is meaningless, and flush overrides any same-cycle claim.
  assign setHit = issueValid && (issueDest != '0) && !flush;

  // Count moves only on real bit transitions. When issue and writeback hit
  // the same register the bit stays set, so nothing is decremented.
  assign incr = setHit && !pending[issueDest];
  assign decr = wbValid && pending[wbReg] && !(setHit && (issueDest == wbReg));

  // Pending bits: flush clears all; otherwise writeback clears, issue sets (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      if (wbValid) pending[wbReg] <= 1'b0;
      if (setHit) pending[issueDest] <= 1'b1;
    end
  end

  // Registered population count of the pending vector, saturating at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendCount <= '0;
    end else if (flush) begin
      pendCount <= '0;
    end else if (incr && !decr && (pendCount != CW'(NUM_REGS - 1))) begin
      pendCount <= pendCount + CW'(1);
    end else if (decr && !incr && (pendCount != '0)) begin
      pendCount <= pendCount - CW'(1);
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gBusy
    logic [AW-1:0] addr;
    assign addr = rdAddr[i*AW +: AW];

    // A source is busy while pending, unless its producer writes back right now.
    always_comb begin
      rdBusy[i] = pending[addr];
      if ((BYPASS != 0) && wbValid && (wbReg == addr)) rdBusy[i] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, optional writeback forwarding,
// and a pending-destination scoreboard for hazard stalls.
//
// issueValid and WBregWrite are valid-only strobes with no ready: each one is
// consumed on the rising edge where it is high and cannot be back-pressured.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     WBregWrite,
  input  logic [AW-1:0]            WBwriteReg,
  input  logic [DATA_W-1:0]        WBresult,
  input  logic [NUM_RD*AW-1:0]     rdAddr,
  output logic [NUM_RD*DATA_W-1:0] rdData,
  output logic [NUM_RD-1:0]        rdBusy,
  input  logic                     issueValid,
  input  logic [AW-1:0]            issueDest,
  input  logic                     flush,
  output logic                     stall,
  output logic [CW-1:0]            pendCount
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wbHit;

  // Writes to r0 are dropped so it always reads as zero.
  assign wbHit = WBregWrite && (WBwriteReg != '0);

  // Register storage; r0 is only ever loaded by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wbHit) begin
      regs[WBwriteReg] <= WBresult;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
    assign addr = rdAddr[i*AW +: AW];

    // Zero-latency read, forwarding the in-flight writeback when enabled.
    always_comb begin
      data = regs[addr];
      if ((BYPASS != 0) && wbHit && (WBwriteReg == addr)) data = WBresult;
      if (addr == '0) data = '0;
    end

    assign rdData[i*DATA_W +: DATA_W] = data;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS)
  ) uScoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issueValid (issueValid),
    .issueDest  (issueDest),
    .wbValid    (WBregWrite),
    .wbReg      (WBwriteReg),
    .flush      (flush),
    .rdAddr     (rdAddr),
    .rdBusy     (rdBusy),
    .pendCount  (pendCount)
  );

  assign stall = |rdBusy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed cases plus a randomized
// phase against a small reference model. A BYPASS=0 twin shares the inputs.
module tb_regfile_scoreboard;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WBregWrite;
  regIdx_t     WBwriteReg;
  logic [31:0] WBresult;
  logic [9:0]  rdAddr;
  logic        issueValid;
  regIdx_t     issueDest;
  logic        flush;

  logic [63:0] rdData, rdDataNb;
  logic [1:0]  rdBusy, rdBusyNb;
  logic        stall, stallNb;
  logic [5:0]  pendCount, pendCountNb;

  int nChecks = 0;
  int nPass   = 0;
  logic [31:0] expQ[$];

  logic [31:0] mdlRegs [32];
  logic [31:0] mdlPend;

  regfile_scoreboard #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .WBregWrite(WBregWrite), .WBwriteReg(WBwriteReg),
    .WBresult(WBresult), .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy),
    .issueValid(issueValid), .issueDest(issueDest), .flush(flush),
    .stall(stall), .pendCount(pendCount)
  );

  regfile_scoreboard #(.BYPASS(0)) dutNb (
    .clk(clk), .rst_n(rst_n), .WBregWrite(WBregWrite), .WBwriteReg(WBwriteReg),
    .WBresult(WBresult), .rdAddr(rdAddr), .rdData(rdDataNb), .rdBusy(rdBusyNb),
    .issueValid(issueValid), .issueDest(issueDest), .flush(flush),
    .stall(stallNb), .pendCount(pendCountNb)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pushExp(input logic [31:0] v);
    expQ.push_back(v);
  endtask

  task automatic popCheck(input string tag, input logic [31:0] obs);
    if (expQ.size() == 0) check({tag, "_qempty"}, 64'(expQ.size()), 64'd1);
    else check(tag, obs, expQ.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input regIdx_t wr, input logic [31:0] wd,
                       input logic iss, input regIdx_t id, input logic fl,
                       input regIdx_t ra0, input regIdx_t ra1);
    WBregWrite = wb; WBwriteReg = wr; WBresult = wd;
    issueValid = iss; issueDest = id; flush = fl;
    rdAddr = {ra1, ra0};
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pendCount", pendCount, 0);
    check("rst_stall", stall, 0);
    check("rst_rdData0", rdData[31:0], 0);
    check("rst_nb_pendCount", pendCountNb, 0);
    rst_n = 1'b1;

    // write r5, read back next cycle
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    pushExp(32'hDEADBEEF);
    @(negedge clk);
    popCheck("r5_read", rdData[31:0]);

    // r0 is hardwired: write and issue both ignored
    tick();
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    pushExp(32'h0);
    @(negedge clk);
    popCheck("r0_bypass", rdData[31:0]);
    check("r0_busy", rdBusy, 0);
    check("r0_stall", stall, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    pushExp(32'h0);
    @(negedge clk);
    popCheck("r0_read", rdData[31:0]);
    check("r0_pendCount", pendCount, 0);

    // same-cycle writeback forwarding vs old value
    tick();
    drive(1, 7, 32'h1234, 0, 0, 0, 0, 7);
    pushExp(32'h1234);
    pushExp(32'h0);
    @(negedge clk);
    popCheck("r7_bypass", rdData[63:32]);
    popCheck("r7_nobypass_old", rdDataNb[63:32]);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    pushExp(32'h1234);
    @(negedge clk);
    popCheck("r7_nobypass_next", rdDataNb[63:32]);

    // issue r3, busy until its writeback
    tick();
    drive(0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    check("r3_pendCount1", pendCount, 1);
    @(negedge clk);
    check("r3_busy", rdBusy[0], 1);
    check("r3_stall", stall, 1);
    tick();
    drive(1, 3, 32'h33, 0, 0, 0, 3, 0);
    @(negedge clk);
    check("r3_wb_busy", rdBusy[0], 0);
    check("r3_wb_stall", stall, 0);
    check("r3_wb_nb_busy", rdBusyNb[0], 1);
    check("r3_wb_pendCount", pendCount, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    check("r3_pendCount0", pendCount, 0);
    check("r3_after_busy", rdBusy[0], 0);

    // r4 pending, then issue and writeback r4 together: stays pending
    drive(0, 0, 0, 1, 4, 0, 0, 0);
    tick();
    check("r4_pendCount1", pendCount, 1);
    drive(1, 4, 32'h44, 1, 4, 0, 4, 0);
    pushExp(32'h44);
    @(negedge clk);
    popCheck("r4_bypass", rdData[31:0]);
    check("r4_same_busy", rdBusy[0], 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 4, 0);
    check("r4_pendCount_keep", pendCount, 1);
    @(negedge clk);
    check("r4_still_busy", rdBusy[0], 1);

    // flush, then r1,r2,r9 pending, flush with issue r10 and write r9
    tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    check("flush_pendCount", pendCount, 0);
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 2, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 9, 0, 0, 0);
    tick();
    check("three_pendCount", pendCount, 3);
    drive(1, 9, 32'h99, 1, 10, 1, 10, 9);
    tick();
    drive(0, 0, 0, 0, 0, 0, 10, 9);
    check("flush2_pendCount", pendCount, 0);
    check("flush2_busy", rdBusy, 0);
    pushExp(32'h99);
    @(negedge clk);
    popCheck("flush2_wb_r9", rdData[63:32]);

    // reset in the middle of activity
    tick();
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    #1;
    check("prerst_stall", stall, 1);
    check("prerst_r5", rdData[63:32], 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", stall, 0);
    check("midrst_busy", rdBusy, 0);
    check("midrst_pendCount", pendCount, 0);
    check("midrst_r5", rdData[63:32], 0);
    drive(1, 5, 32'h55, 1, 6, 0, 6, 5);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 6, 5);
    #1;
    check("inrst_wb_ignored", rdData[63:32], 0);
    check("inrst_issue_ignored", pendCount, 0);
    rst_n = 1'b1;
    tick();

    // randomized traffic against a reference model
    for (int r = 0; r < 32; r++) mdlRegs[r] = '0;
    mdlPend = '0;
    for (int c = 0; c < 300; c++) begin
      logic        wb, iss, fl;
      regIdx_t     wr, id, a0, a1;
      logic [31:0] wd;
      logic [1:0]  expBusy;
      wb  = ($urandom_range(0, 1) == 1);
      wr  = regIdx_t'($urandom_range(0, 31));
      wd  = $urandom;
      iss = ($urandom_range(0, 2) != 0);
      id  = regIdx_t'($urandom_range(0, 31));
      fl  = ($urandom_range(0, 15) == 0);
      a0  = ($urandom_range(0, 2) == 0) ? wr : regIdx_t'($urandom_range(0, 31));
      a1  = ($urandom_range(0, 2) == 0) ? id : regIdx_t'($urandom_range(0, 31));
      drive(wb, wr, wd, iss, id, fl, a0, a1);
      for (int p = 0; p < 2; p++) begin
        regIdx_t a;
        a = (p == 0) ? a0 : a1;
        if (a == 0) pushExp(32'h0);
        else if (wb && wr == a) pushExp(wd);
        else pushExp(mdlRegs[a]);
        expBusy[p] = (a != 0) && mdlPend[a] && !(wb && wr == a);
      end
      @(negedge clk);
      popCheck("rnd_rdData0", rdData[31:0]);
      popCheck("rnd_rdData1", rdData[63:32]);
      check("rnd_busy", rdBusy, expBusy);
      check("rnd_stall", stall, |expBusy);
      check("rnd_pendCount", pendCount, $countones(mdlPend));
      if (wb && wr != 0) mdlRegs[wr] = wd;
      if (fl) mdlPend = '0;
      else begin
        if (wb) mdlPend[wr] = 1'b0;
        if (iss && id != 0) mdlPend[id] = 1'b1;
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rnd_final_pendCount", pendCount, $countones(mdlPend));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
